ext_mem_result_writer: RTL and testbench

//  Write-back end of the external-memory image path: the image core reads pixel pairs over data_in1/data_in2 at ext_mem_adr.

---
 rtl/ext_mem_result_writer_pkg.sv | 17 +
 rtl/ext_mem_result_writer_adr_gen.sv | 49 ++++
 rtl/ext_mem_result_writer.sv | 164 ++++++++++++++++
 tb/tb_ext_mem_result_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_result_writer_pkg.sv
// Shared types and default widths for the external-memory result writer.
// The optional checksum feature is enabled with the WR_CHECKSUM_EN macro.
package ext_mem_result_writer_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADR_W_DEF  = 8;
   localparam int unsigned CSUM_W     = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_LO = 3'd1,
      GET_HI = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/ext_mem_result_writer_adr_gen.sv
// Write-address generator: holds the image base address and word counter,
// presents base+count (wrapping) and flags the last word of the image.
module ext_mem_result_writer_adr_gen
   import ext_mem_result_writer_pkg::*;
#(
   parameter int unsigned ADR_W      = ADR_W_DEF,
   parameter int unsigned IMG_PIXELS = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             inc,
   input  logic [ADR_W-1:0] base_adr,
   output logic [ADR_W-1:0] adr_c,
   output logic             last_word_c
);

   localparam int unsigned WORDS = IMG_PIXELS / 2;
   localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [ADR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      base_d = base_q;
      cnt_d  = cnt_q;
      if (load) begin
         base_d = base_adr;
         cnt_d  = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         base_q <= '0;
         cnt_q  <= '0;
      end else begin
         base_q <= base_d;
         cnt_q  <= cnt_d;
      end
   end

   // Address arithmetic is modulo 2^ADR_W by construction.
   assign adr_c       = base_q + ADR_W'(cnt_q);
   assign last_word_c = (cnt_q == CNT_W'(WORDS - 1));

endmodule

// File: rtl/ext_mem_result_writer.sv
// Packs the processed pixel stream into pairs and writes them to the external
// result memory. Define WR_CHECKSUM_EN to add the per-image 16-bit checksum.
module ext_mem_result_writer
   import ext_mem_result_writer_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ADR_W      = ADR_W_DEF,
   parameter int unsigned IMG_PIXELS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADR_W-1:0]  base_adr,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              wr_en,
   output logic [ADR_W-1:0]  wr_adr,
   output logic [DATA_W-1:0] wr_data1,
   output logic [DATA_W-1:0] wr_data2,
   output logic              busy,
   output logic              complete
`ifdef WR_CHECKSUM_EN
   ,
   output logic [CSUM_W-1:0] checksum
`endif
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              pix_ready_q, pix_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADR_W-1:0]  wr_adr_q, wr_adr_d;
   logic [DATA_W-1:0] wr_data1_q, wr_data1_d;
   logic [DATA_W-1:0] wr_data2_q, wr_data2_d;
   logic              busy_q, busy_d;
   logic              complete_q, complete_d;
   logic              load_c, inc_c;
   logic [ADR_W-1:0]  adr_c;
   logic              last_word_c;
`ifdef WR_CHECKSUM_EN
   logic [CSUM_W-1:0] csum_q, csum_d;
`endif

   ext_mem_result_writer_adr_gen #(
      .ADR_W      (ADR_W),
      .IMG_PIXELS (IMG_PIXELS)
   ) u_adr_gen (
      .clk         (clk),
      .reset       (reset),
      .load        (load_c),
      .inc         (inc_c),
      .base_adr    (base_adr),
      .adr_c       (adr_c),
      .last_word_c (last_word_c)
   );

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      wr_en_d    = 1'b0;
      wr_adr_d   = wr_adr_q;
      wr_data1_d = wr_data1_q;
      wr_data2_d = wr_data2_q;
      busy_d     = busy_q;
      complete_d = complete_q;
      load_c     = 1'b0;
      inc_c      = 1'b0;
`ifdef WR_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               load_c     = 1'b1;
               busy_d     = 1'b1;
               complete_d = 1'b0;
`ifdef WR_CHECKSUM_EN
               csum_d     = '0;
`endif
               state_d    = GET_LO;
            end
         end
         GET_LO: begin
            if (pix_valid && pix_ready_q) begin
               lo_d    = pix_in;
               state_d = GET_HI;
            end
         end
         GET_HI: begin
            // Write strobe and payload are registered so they appear in WRITE.
            if (pix_valid && pix_ready_q) begin
               wr_en_d    = 1'b1;
               wr_adr_d   = adr_c;
               wr_data1_d = lo_q;
               wr_data2_d = pix_in;
               state_d    = WRITE;
            end
         end
         WRITE: begin
`ifdef WR_CHECKSUM_EN
            csum_d = csum_q + CSUM_W'(wr_data1_q) + CSUM_W'(wr_data2_q);
`endif
            if (last_word_c) begin
               busy_d     = 1'b0;
               complete_d = 1'b1;
               state_d    = DONE;
            end else begin
               inc_c   = 1'b1;
               state_d = GET_LO;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      pix_ready_d = (state_d == GET_LO) || (state_d == GET_HI);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         lo_q        <= '0;
         pix_ready_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_adr_q    <= '0;
         wr_data1_q  <= '0;
         wr_data2_q  <= '0;
         busy_q      <= 1'b0;
         complete_q  <= 1'b0;
`ifdef WR_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         pix_ready_q <= pix_ready_d;
         wr_en_q     <= wr_en_d;
         wr_adr_q    <= wr_adr_d;
         wr_data1_q  <= wr_data1_d;
         wr_data2_q  <= wr_data2_d;
         busy_q      <= busy_d;
         complete_q  <= complete_d;
`ifdef WR_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign pix_ready = pix_ready_q;
   assign wr_en     = wr_en_q;
   assign wr_adr    = wr_adr_q;
   assign wr_data1  = wr_data1_q;
   assign wr_data2  = wr_data2_q;
   assign busy      = busy_q;
   assign complete  = complete_q;
`ifdef WR_CHECKSUM_EN
   assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_ext_mem_result_writer.sv
// Directed, table-driven bench for ext_mem_result_writer (default 8/8/64 build);
// checksum checks are compiled in when WR_CHECKSUM_EN is defined.
module tb_ext_mem_result_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_adr;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        pix_ready;
   logic        wr_en;
   logic [7:0]  wr_adr;
   logic [7:0]  wr_data1;
   logic [7:0]  wr_data2;
   logic        busy;
   logic        complete;
`ifdef WR_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int errors = 0;
   int checks = 0;

   ext_mem_result_writer #(
      .DATA_W     (8),
      .ADR_W      (8),
      .IMG_PIXELS (64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_adr  (base_adr),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .wr_en     (wr_en),
      .wr_adr    (wr_adr),
      .wr_data1  (wr_data1),
      .wr_data2  (wr_data2),
      .busy      (busy),
      .complete  (complete)
`ifdef WR_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Write log and pix_ready-during-write counter, sampled mid-cycle.
   logic [23:0] wq[$];
   int          rdy_in_write = 0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wq.push_back({wr_adr, wr_data1, wr_data2});
         if (pix_ready === 1'b1) rdy_in_write++;
      end
   end

   typedef struct {
      logic [7:0]  base;
      bit          toggle;
      bit          all_ff;
      bit          glitch;
      logic [7:0]  exp_first_adr;
      logic [7:0]  exp_last_adr;
      int          exp_writes;
      logic [15:0] exp_csum;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input bit ok,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pv(input bit all_ff, input int p);
      return all_ff ? 8'hFF : 8'(p);
   endfunction

   task automatic issue_start(input logic [7:0] b);
      @(posedge clk); #1;
      start    = 1'b1;
      base_adr = b;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   // Offers pixels until npix are consumed; returns one step after the last handshake edge.
   task automatic run_stream(input vec_t v, input int npix, input string tag);
      int p   = 0;
      int cyc = 0;
      bit fire;
      while (p < npix && cyc < 1000) begin
         pix_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
         pix_in    = pv(v.all_ff, p);
         start     = v.glitch && (p == 7);
         if (start) base_adr = 8'hAA;
         @(negedge clk);
         fire = pix_valid && pix_ready;
         @(posedge clk); #1;
         if (fire) p++;
         cyc++;
      end
      pix_valid = 1'b0;
      start     = 1'b0;
      check({tag, "_stream"}, p == npix, p, npix);
   endtask

   task automatic wait_complete(input string tag);
      int n = 0;
      while (complete !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_complete"}, complete === 1'b1, complete, 1);
      check({tag, "_busy"}, busy === 1'b0, busy, 0);
   endtask

   task automatic run_vec(input int k, input vec_t v);
      string       tag = $sformatf("v%0d", k);
      int          w0  = wq.size();
      int          r0  = rdy_in_write;
      int          nw;
      logic [23:0] got;
      logic [23:0] exp;
      issue_start(v.base);
      run_stream(v, 64, tag);
      if (v.glitch) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      wait_complete(tag);
`ifdef WR_CHECKSUM_EN
      check({tag, "_csum"}, checksum === v.exp_csum, checksum, v.exp_csum);
`endif
      nw = wq.size() - w0;
      check({tag, "_writes"}, nw == v.exp_writes, nw, v.exp_writes);
      check({tag, "_rdy_in_write"}, rdy_in_write == r0, rdy_in_write - r0, 0);
      if (nw == v.exp_writes) begin
         check({tag, "_first_adr"}, wq[w0][23:16] === v.exp_first_adr,
               wq[w0][23:16], v.exp_first_adr);
         check({tag, "_last_adr"}, wq[w0 + nw - 1][23:16] === v.exp_last_adr,
               wq[w0 + nw - 1][23:16], v.exp_last_adr);
         for (int i = 0; i < nw; i++) begin
            got = wq[w0 + i];
            exp = {v.base + 8'(i), pv(v.all_ff, 2 * i), pv(v.all_ff, 2 * i + 1)};
            check($sformatf("%s_word%0d", tag, i), got === exp, got, exp);
         end
      end
   endtask

   initial begin
      int   n0;
      vec_t mid;

      //        base   tgl ff  glt first  last   n   csum
      vecs[0] = '{8'h10, 0, 0, 0, 8'h10, 8'h2F, 32, 16'h07E0};
      vecs[1] = '{8'h10, 1, 0, 0, 8'h10, 8'h2F, 32, 16'h07E0};
      vecs[2] = '{8'hF0, 0, 0, 0, 8'hF0, 8'h0F, 32, 16'h07E0};
      vecs[3] = '{8'h00, 1, 1, 0, 8'h00, 8'h1F, 32, 16'h3FC0};
      vecs[4] = '{8'h40, 0, 0, 1, 8'h40, 8'h5F, 32, 16'h07E0};

      reset     = 1'b0;
      start     = 1'b0;
      base_adr  = 8'h00;
      pix_in    = 8'h00;
      pix_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {pix_ready, wr_en, busy, complete} === 4'b0,
            {pix_ready, wr_en, busy, complete}, 0);
      check("rst_data", {wr_adr, wr_data1, wr_data2} === 24'h0,
            {wr_adr, wr_data1, wr_data2}, 0);
`ifdef WR_CHECKSUM_EN
      check("rst_csum", checksum === 16'h0, checksum, 0);
`endif
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("idle_no_ready", pix_ready === 1'b0, pix_ready, 0);

      for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

      // A start in IDLE after completion clears complete.
      issue_start(8'h80);
      @(negedge clk);
      check("restart_complete", complete === 1'b0, complete, 0);
      check("restart_busy", busy === 1'b1, busy, 1);
      check("restart_ready", pix_ready === 1'b1, pix_ready, 1);

      // Reset after 10 pixels: the 5th write is in flight, nothing after it.
      mid = vecs[0];
      n0  = wq.size();
      run_stream(mid, 10, "mid");
      reset = 1'b0;
      @(posedge clk); #1;
      check("mid_writes_before", wq.size() - n0 == 5, wq.size() - n0, 5);
      n0 = wq.size();
      @(negedge clk);
      check("mid_rst_outs", {pix_ready, wr_en, busy, complete, wr_adr, wr_data1, wr_data2} === 28'h0,
            {pix_ready, wr_en, busy, complete, wr_adr, wr_data1, wr_data2}, 0);
      reset     = 1'b1;
      pix_valid = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_no_more_writes", wq.size() == n0, wq.size() - n0, 0);
      check("mid_idle_ready", pix_ready === 1'b0, pix_ready, 0);
      pix_valid = 1'b0;

      run_vec(5, vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
